// File: rtl/sprite_blitter.sv
// Sprite blitter: copies an SPR_W x SPR_H sprite from a synchronous ROM into the frame store.
// Defining BLIT_MIRROR_EN adds the mirror_x input for horizontal flipping.
module sprite_blitter #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int FB_AW  = 18,
  parameter int SPR_W  = 32,
  parameter int SPR_H  = 32,
  parameter int SPR_AW = 10,
  parameter int CIDX_W = 5,
  parameter int TRANSP = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [10:0]       pos_x,
  input  logic [10:0]       pos_y,
`ifdef BLIT_MIRROR_EN
  input  logic              mirror_x,
`endif
  output logic              busy,
  output logic              done,
  output logic [SPR_AW-1:0] spr_addr,
  input  logic [CIDX_W-1:0] spr_data,
  output logic              fb_we,
  output logic [FB_AW-1:0]  fb_addr,
  output logic [CIDX_W-1:0] fb_wdata
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int DW = 12;
  localparam logic signed [DW-1:0] FB_W_S = DW'(FB_W);
  localparam logic signed [DW-1:0] FB_H_S = DW'(FB_H);
  localparam logic signed [DW-1:0] ZERO_S = '0;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                   state_q;
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic signed [DW-1:0]     posx_q, posy_q;
  logic signed [DW-1:0]     s1x_q, s1y_q, s2x_q, s2y_q;
  logic                     s1v_q, s2v_q;
  logic                     drain_q, mirror_q;
  logic                     busy_q, done_q, fb_we_q;
  logic [SPR_AW-1:0]        spr_addr_q;
  logic [FB_AW-1:0]         fb_addr_q, fb_addr_d;
  logic [CIDX_W-1:0]        fb_wdata_q;
  logic                     last_pix, wr_en, mirror_in;
  logic signed [DW-1:0]     posx_in, posy_in;

`ifdef BLIT_MIRROR_EN
  assign mirror_in = mirror_x;
`else
  assign mirror_in = 1'b0;
`endif

  // Sign-extend to 12 bits so pos + col/row can never wrap into a neighbouring row.
  assign posx_in = {pos_x[10], pos_x};
  assign posy_in = {pos_y[10], pos_y};

  function automatic logic [SPR_AW-1:0] romAddr(input logic [CW-1:0] c,
                                                input logic [RW-1:0] r,
                                                input logic          m);
    int cc;
    cc = m ? (SPR_W - 1 - int'(c)) : int'(c);
    return SPR_AW'(int'(r) * SPR_W + cc);
  endfunction

  always_comb begin
    col_d    = col_q + CW'(1);
    row_d    = row_q;
    if (col_q == CW'(SPR_W - 1)) begin
      col_d = '0;
      row_d = row_q + RW'(1);
    end
    last_pix  = (col_q == CW'(SPR_W - 1)) && (row_q == RW'(SPR_H - 1));
    // Stage 2 pairs the returning ROM data with the destination it was issued for.
    wr_en     = s2v_q && (s2x_q >= ZERO_S) && (s2x_q < FB_W_S) &&
                (s2y_q >= ZERO_S) && (s2y_q < FB_H_S) &&
                (spr_data != CIDX_W'(TRANSP));
    fb_addr_d = FB_AW'(int'(s2y_q) * FB_W + int'(s2x_q));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      posx_q     <= '0;
      posy_q     <= '0;
      s1x_q      <= '0;
      s1y_q      <= '0;
      s2x_q      <= '0;
      s2y_q      <= '0;
      s1v_q      <= 1'b0;
      s2v_q      <= 1'b0;
      drain_q    <= 1'b0;
      mirror_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fb_we_q    <= 1'b0;
      spr_addr_q <= '0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
    end else begin
      done_q  <= 1'b0;
      fb_we_q <= wr_en;
      if (wr_en) begin
        fb_addr_q  <= fb_addr_d;
        fb_wdata_q <= spr_data;
      end
      s2x_q <= s1x_q;
      s2y_q <= s1y_q;
      s2v_q <= s1v_q;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= RUN;
            busy_q     <= 1'b1;
            col_q      <= '0;
            row_q      <= '0;
            posx_q     <= posx_in;
            posy_q     <= posy_in;
            mirror_q   <= mirror_in;
            spr_addr_q <= romAddr('0, '0, mirror_in);
            s1x_q      <= posx_in;
            s1y_q      <= posy_in;
            s1v_q      <= 1'b1;
          end
        end
        RUN: begin
          if (last_pix) begin
            state_q <= DRAIN;
            s1v_q   <= 1'b0;
            drain_q <= 1'b0;
          end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            spr_addr_q <= romAddr(col_d, row_d, mirror_q);
            s1x_q      <= posx_q + DW'(col_d);
            s1y_q      <= posy_q + DW'(row_d);
          end
        end
        DRAIN: begin
          if (drain_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign spr_addr = spr_addr_q;
  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_wdata = fb_wdata_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter with a 4x4 sprite and ROM[i] = i[4:0].
// Builds with or without BLIT_MIRROR_EN; mirror checks only run when it is defined.
module tb_sprite_blitter;

  localparam int SPR = 4;
  localparam int N   = SPR * SPR;
  localparam int P   = N + 4;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        start;
  logic [10:0] pos_x, pos_y;
  logic        mirror_x;
  logic        busy, done, fb_we;
  logic [3:0]  spr_addr;
  logic [4:0]  spr_data;
  logic [17:0] fb_addr;
  logic [4:0]  fb_wdata;

  int checks = 0;
  int errors = 0;

  sprite_blitter #(.SPR_W(SPR), .SPR_H(SPR), .SPR_AW(4)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .start    (start),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
`ifdef BLIT_MIRROR_EN
    .mirror_x (mirror_x),
`endif
    .busy     (busy),
    .done     (done),
    .spr_addr (spr_addr),
    .spr_data (spr_data),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_wdata (fb_wdata)
  );

  always #5 Clk = ~Clk;

  // Synchronous sprite ROM: data for an address appears one cycle later.
  always @(posedge Clk) spr_data <= {1'b0, spr_addr};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One blit, checked every cycle against a pixel-by-pixel reference of the draw rules.
  task automatic applyStimulus(input int px, input int py, input logic mir,
                               output int nWr, output int firstAddr, output int firstData);
    logic expWe;
    int   expAddr, expData, i, row, col, src, x, y;
    nWr = 0;
    firstAddr = -1;
    firstData = -1;
    @(negedge Clk);
    pos_x    = 11'(px);
    pos_y    = 11'(py);
    mirror_x = mir;
    start    = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    for (int k = 1; k <= N + 4; k++) begin
      expWe = 1'b0;
      expAddr = 0;
      expData = 0;
      if (k >= 3 && k <= N + 2) begin
        i       = k - 3;
        row     = i / SPR;
        col     = i % SPR;
        src     = row * SPR + (mir ? (SPR - 1 - col) : col);
        expData = src % 32;
        x       = px + col;
        y       = py + row;
        expWe   = (x >= 0 && x < 320 && y >= 0 && y < 240 && expData != 0);
        expAddr = y * 320 + x;
      end
      checkOutput("busy", busy, k <= N + 3);
      checkOutput("done", done, k == N + 3);
      checkOutput("fb_we", fb_we, expWe);
      if (fb_we === 1'b1) begin
        nWr++;
        if (firstAddr < 0) begin
          firstAddr = int'(fb_addr);
          firstData = int'(fb_wdata);
        end
      end
      if (expWe) begin
        checkOutput("fb_addr", fb_addr, expAddr);
        checkOutput("fb_wdata", fb_wdata, expData);
      end
      if (k < N + 4) @(negedge Clk);
    end
  endtask

  initial begin
    int nWr, fAddr, fData, px, py;
    logic mir;
    Reset_n  = 1'b0;
    start    = 1'b0;
    pos_x    = '0;
    pos_y    = '0;
    mirror_x = 1'b0;

    #1;
    $display("[TB] reset state");
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_fb_we", fb_we, 0);
    checkOutput("rst_spr_addr", spr_addr, 0);
    checkOutput("rst_fb_addr", fb_addr, 0);
    checkOutput("rst_fb_wdata", fb_wdata, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    $display("[TB] reset during RUN");
    @(negedge Clk);
    pos_x = 11'd10;
    pos_y = 11'd20;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (5) @(negedge Clk);
    checkOutput("mid_spr_addr", spr_addr, 5);
    checkOutput("mid_fb_we", fb_we, 1);
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_fb_we", fb_we, 0);
    checkOutput("abort_spr_addr", spr_addr, 0);
    checkOutput("abort_fb_addr", fb_addr, 0);
    checkOutput("abort_fb_wdata", fb_wdata, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      checkOutput("post_abort_fb_we", fb_we, 0);
      checkOutput("post_abort_busy", busy, 0);
    end

    $display("[TB] blit at (10,20)");
    applyStimulus(10, 20, 1'b0, nWr, fAddr, fData);
    checkOutput("writes_10_20", nWr, 15);
    checkOutput("first_addr_10_20", fAddr, 6411);
    checkOutput("first_data_10_20", fData, 1);

    $display("[TB] blit at (-2,238)");
    applyStimulus(-2, 238, 1'b0, nWr, fAddr, fData);
    checkOutput("writes_clip", nWr, 4);
    checkOutput("first_addr_clip", fAddr, 76160);
    checkOutput("first_data_clip", fData, 2);

    $display("[TB] blit at (400,0)");
    applyStimulus(400, 0, 1'b0, nWr, fAddr, fData);
    checkOutput("writes_offscreen", nWr, 0);

    $display("[TB] start held high");
    @(negedge Clk);
    pos_x = 11'd5;
    pos_y = 11'd5;
    start = 1'b1;
    for (int k = 1; k < 3 * P; k++) begin
      @(negedge Clk);
      checkOutput("held_busy", busy, (k % P) != 0);
      checkOutput("held_done", done, (k % P) == N + 3);
    end
    start = 1'b0;
    repeat (2) begin
      @(negedge Clk);
      checkOutput("held_idle_busy", busy, 0);
    end

`ifdef BLIT_MIRROR_EN
    $display("[TB] mirrored blit at (0,0)");
    applyStimulus(0, 0, 1'b1, nWr, fAddr, fData);
    checkOutput("writes_mirror", nWr, 15);
    checkOutput("first_addr_mirror", fAddr, 0);
    checkOutput("first_data_mirror", fData, 3);
`endif

    $display("[TB] random blits");
    for (int r = 0; r < 10; r++) begin
      px  = int'($urandom_range(0, 460)) - 50;
      py  = int'($urandom_range(0, 340)) - 50;
`ifdef BLIT_MIRROR_EN
      mir = 1'($urandom_range(0, 1));
`else
      mir = 1'b0;
`endif
      applyStimulus(px, py, mir, nWr, fAddr, fData);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
